data_mem_ctrl: RTL and testbench

//  Sequencer between the CPU load/store stage and the byte-wide data memory.

---
 rtl/data_mem_ctrl.sv | 124 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - load/store sequencer onto a byte-wide data memory
// Issues one memory byte per cycle, big-endian, and sign/zero-extends load results.
module data_mem_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [1:0]        req_size,
  input  logic              req_se,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rw;
  logic [1:0]        r_size;
  logic              r_se;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_cnt;
  logic [1:0]        r_last;
  logic              r_err;
  logic [23:0]       r_shift;
  logic [31:0]       r_rdata;

  logic              w_accept;
  logic              w_misaligned;
  logic              w_last_byte;
  logic [31:0]       w_assembled;
  logic [31:0]       w_extended;

  assign w_accept     = req_valid & req_ready;
  assign w_misaligned = ((req_size == 2'b01) & req_addr[0]) |
                        (req_size[1] & (req_addr[1:0] != 2'b00));
  assign w_last_byte  = (r_cnt == r_last);
  // Final load byte arrives during CAPTURE and is appended below the earlier ones.
  assign w_assembled  = {r_shift, mem_rdata};

  always_comb begin
    w_extended = w_assembled;
    case (r_size)
      2'b00:   w_extended = {{24{r_se & w_assembled[7]}}, w_assembled[7:0]};
      2'b01:   w_extended = {{16{r_se & w_assembled[15]}}, w_assembled[15:0]};
      default: w_extended = w_assembled;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    rsp_err   = (r_state == S_RESP) & r_err;
    mem_en    = (r_state == S_ACCESS);
    mem_we    = (r_state == S_ACCESS) & r_rw;
    mem_addr  = r_addr + ADDR_W'(r_cnt);
    mem_wdata = r_wdata[31:24];
    rsp_rdata = r_rdata;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_misaligned ? S_RESP : S_ACCESS;
      S_ACCESS:  if (w_last_byte) w_next = r_rw ? S_RESP : S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_rw    <= 1'b0;
      r_size  <= 2'b00;
      r_se    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= 2'd0;
      r_last  <= 2'd0;
      r_err   <= 1'b0;
      r_shift <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rw   <= req_rw;
          r_size <= req_size;
          r_se   <= req_se;
          r_addr <= req_addr;
          r_cnt  <= 2'd0;
          r_err  <= w_misaligned;
          // Store data is left-justified so the MSB byte always leaves first.
          case (req_size)
            2'b00:   begin r_last <= 2'd0; r_wdata <= {req_wdata[7:0], 24'h0};  end
            2'b01:   begin r_last <= 2'd1; r_wdata <= {req_wdata[15:0], 16'h0}; end
            default: begin r_last <= 2'd3; r_wdata <= req_wdata;                end
          endcase
          if (w_misaligned) r_rdata <= '0;
        end
        S_ACCESS: begin
          r_wdata <= r_wdata << 8;
          r_cnt   <= w_last_byte ? 2'd0 : r_cnt + 2'd1;
          if (!r_rw && (r_cnt != 2'd0)) r_shift <= {r_shift[15:0], mem_rdata};
          if (r_rw && w_last_byte) r_rdata <= '0;
        end
        S_CAPTURE: r_rdata <= w_extended;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed self-checking bench for data_mem_ctrl
// A byte-array memory model answers reads one cycle after mem_en.
module tb_data_mem_ctrl;
  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_rw, req_se;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata, mem_rdata;

  logic [7:0]        mem [0:511];
  int                en_cnt = 0;
  int                n_checks = 0;
  int                n_pass = 0;
  logic [ADDR_W-1:0] log_addr [8];
  logic [7:0]        log_wd [8];
  int                log_n;

  data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_se(req_se), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic do_req(input logic rw, input logic [1:0] size, input logic se,
                        input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    @(negedge clk);
    check("ready_before_accept", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_se = se;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; log_n = 0; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_en && log_n < 8) begin
        log_addr[log_n] = mem_addr; log_wd[log_n] = mem_wdata; log_n++;
      end
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
    check("rsp_seen", 32'(lat != 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, en0, nv, n_acc, n_low;
    int          acc [8];

    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_se = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_rsp_rdata", rsp_rdata,      32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hA1B2C3D4, rd, er, lat);
    check("sw_lat", 32'(lat), 32'd5);
    check("sw_err", 32'(er), 32'd0);
    check("sw_rdata", rd, 32'd0);
    check("sw_nbytes", 32'(log_n), 32'd4);
    check("sw_addr0", 32'(log_addr[0]), 32'h010);
    check("sw_addr3", 32'(log_addr[3]), 32'h013);
    check("sw_wd0", 32'(log_wd[0]), 32'hA1);
    check("sw_wd3", 32'(log_wd[3]), 32'hD4);
    check("sw_mem", {mem[16], mem[17], mem[18], mem[19]}, 32'hA1B2C3D4);

    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0, rd, er, lat);
    check("lw_lat", 32'(lat), 32'd6);
    check("lw_err", 32'(er), 32'd0);
    check("lw_rdata", rd, 32'hA1B2C3D4);
    @(negedge clk);
    check("lw_hold", rsp_rdata, 32'hA1B2C3D4);

    do_req(1'b1, 2'b00, 1'b0, 9'h020, 32'h00000085, rd, er, lat);
    check("sb_lat", 32'(lat), 32'd2);
    do_req(1'b1, 2'b00, 1'b0, 9'h021, 32'hFFFFFF11, rd, er, lat);
    check("sb_mem21", 32'(mem[9'h021]), 32'h11);
    do_req(1'b0, 2'b00, 1'b1, 9'h020, 32'h0, rd, er, lat);
    check("lb_se_lat", 32'(lat), 32'd3);
    check("lb_se", rd, 32'hFFFFFF85);
    do_req(1'b0, 2'b00, 1'b0, 9'h020, 32'h0, rd, er, lat);
    check("lb_ze", rd, 32'h00000085);
    do_req(1'b0, 2'b01, 1'b1, 9'h020, 32'h0, rd, er, lat);
    check("lh_se_lat", 32'(lat), 32'd4);
    check("lh_se", rd, 32'hFFFF8511);
    do_req(1'b0, 2'b01, 1'b0, 9'h020, 32'h0, rd, er, lat);
    check("lh_ze", rd, 32'h00008511);

    en0 = en_cnt;
    do_req(1'b0, 2'b01, 1'b1, 9'h031, 32'h0, rd, er, lat);
    check("mis_lh_lat", 32'(lat), 32'd1);
    check("mis_lh_err", 32'(er), 32'd1);
    check("mis_lh_rdata", rd, 32'd0);
    do_req(1'b1, 2'b10, 1'b0, 9'h042, 32'hCAFEF00D, rd, er, lat);
    check("mis_sw_lat", 32'(lat), 32'd1);
    check("mis_sw_err", 32'(er), 32'd1);
    check("mis_no_mem", 32'(en_cnt - en0), 32'd0);

    do_req(1'b1, 2'b11, 1'b0, 9'h1FC, 32'h12345678, rd, er, lat);
    check("top_addr0", 32'(log_addr[0]), 32'h1FC);
    check("top_addr3", 32'(log_addr[3]), 32'h1FF);
    do_req(1'b0, 2'b10, 1'b0, 9'h1FC, 32'h0, rd, er, lat);
    check("top_rdata", rd, 32'h12345678);

    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b10; req_addr = 9'h080;
    req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_en", 32'(mem_en), 32'd1);
    check("abort_pre_addr", 32'(mem_addr), 32'h081);
    reset = 1'b1;
    #1;
    check("abort_en_drop", 32'(mem_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid || mem_en) nv++;
    end
    check("abort_quiet", 32'(nv), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_mem80", 32'(mem[9'h080]), 32'hDE);
    check("abort_mem81", 32'(mem[9'h081]), 32'h00);

    @(negedge clk);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'b00; req_addr = 9'h050;
    req_wdata = 32'h0000005A;
    n_acc = 0; n_low = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if (req_ready) begin
        if (n_acc < 8) acc[n_acc] = c;
        n_acc++;
      end else n_low++;
    end
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_accepts", 32'(n_acc), 32'd4);
    check("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    check("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    check("b2b_ready_low", 32'(n_low), 32'd8);
    check("b2b_mem", 32'(mem[9'h050]), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
